// File: rtl/a2600_bs_pkg.sv
// a2600_bs_pkg: shared definitions for the cartridge bank-switch detector.
//   - force_bs code values understood by the console core
//   - detector FSM state encoding
//   - ROM image size constants (17-bit so 64K is representable)
//   - bs_decide(): maps image size and signature hits to a force_bs code
package a2600_bs_pkg;

  localparam logic [3:0] BS_NONE = 4'd0;
  localparam logic [3:0] BS_F8   = 4'd1;
  localparam logic [3:0] BS_F6   = 4'd2;
  localparam logic [3:0] BS_FE   = 4'd3;
  localparam logic [3:0] BS_E0   = 4'd4;
  localparam logic [3:0] BS_3F   = 4'd5;
  localparam logic [3:0] BS_F4   = 4'd6;
  localparam logic [3:0] BS_P2   = 4'd7;
  localparam logic [3:0] BS_FA   = 4'd8;
  localparam logic [3:0] BS_CV   = 4'd9;
  localparam logic [3:0] BS_UA   = 4'd11;
  localparam logic [3:0] BS_E7   = 4'd12;
  localparam logic [3:0] BS_F0   = 4'd13;
  localparam logic [3:0] BS_32   = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2,
    ST_DONE   = 2'd3
  } bs_state_e;

  localparam logic [16:0] SIZE_4K  = 17'd4096;
  localparam logic [16:0] SIZE_8K  = 17'd8192;
  localparam logic [16:0] SIZE_12K = 17'd12288;
  localparam logic [16:0] SIZE_16K = 17'd16384;
  localparam logic [16:0] SIZE_32K = 17'd32768;
  localparam logic [16:0] SIZE_64K = 17'h10000;

  // First matching rule wins; small images never bank-switch.
  function automatic logic [3:0] bs_decide(
    input logic [16:0] size,
    input logic        hit_e0,
    input logic        hit_e7,
    input logic        hit_fe,
    input logic        hit_3f
  );
    logic [3:0] code;
    code = BS_NONE;
    if (size <= SIZE_4K)                  code = BS_NONE;
    else if (hit_3f)                      code = BS_3F;
    else if (hit_e0 && size == SIZE_8K)   code = BS_E0;
    else if (hit_fe && size == SIZE_8K)   code = BS_FE;
    else if (size == SIZE_8K)             code = BS_F8;
    else if (size == SIZE_12K)            code = BS_FA;
    else if (size == SIZE_16K)            code = hit_e7 ? BS_E7 : BS_F6;
    else if (size == SIZE_32K)            code = BS_F4;
    else if (size == SIZE_64K)            code = BS_F0;
    else                                  code = BS_NONE;
    return code;
  endfunction

endpackage

// File: rtl/bs_sig_match.sv
// bs_sig_match: combinational hotspot signature matcher.
//   w2, w1, w0 : 3-byte window, w0 newest
//   hit_e0     : 8D E0 1F | 8D E0 5F | 8D E0 FF | AD E0 1F
//   hit_e7     : AD E5 FF | 8D E7 FF
//   hit_fe     : 20 00 D0
//   hit_3f     : 85 3F in w1/w0
module bs_sig_match (
  input  logic [7:0] w2,
  input  logic [7:0] w1,
  input  logic [7:0] w0,
  output logic       hit_e0,
  output logic       hit_e7,
  output logic       hit_fe,
  output logic       hit_3f
);

  assign hit_e0 = ((w2 == 8'h8D) && (w1 == 8'hE0) &&
                   ((w0 == 8'h1F) || (w0 == 8'h5F) || (w0 == 8'hFF))) ||
                  ((w2 == 8'hAD) && (w1 == 8'hE0) && (w0 == 8'h1F));

  assign hit_e7 = ((w2 == 8'hAD) && (w1 == 8'hE5) && (w0 == 8'hFF)) ||
                  ((w2 == 8'h8D) && (w1 == 8'hE7) && (w0 == 8'hFF));

  assign hit_fe = (w2 == 8'h20) && (w1 == 8'h00) && (w0 == 8'hD0);

  assign hit_3f = (w1 == 8'h85) && (w0 == 8'h3F);

endmodule

// File: rtl/cart_bs_detect.sv
// cart_bs_detect: snoops the ioctl ROM download, scans for bank-switch
// signatures and a SuperChip fill pattern, and publishes a force_bs code.
//   clk, reset         : clock, synchronous active-high reset
//   ioctl_download     : high for the whole download
//   ioctl_wr           : one-cycle strobe per byte
//   ioctl_addr/dout    : byte address / data
//   bs_code, sc_det    : decision, held until the next decision
//   bs_valid           : one-cycle pulse when bs_code/sc_det update
//   rom_size           : highest accepted address + 1 (max 17'h10000)
module cart_bs_detect
  import a2600_bs_pkg::*;
#(
  parameter int SC_LEN = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [3:0]  bs_code,
  output logic        bs_valid,
  output logic        sc_det,
  output logic [16:0] rom_size
);

  localparam logic [16:0] SC_LEN_W = 17'(SC_LEN);

  bs_state_e   state_r, state_nxt_s;
  logic        dl_prev_r;
  logic        dl_rise_s, dl_fall_s;
  logic        scan_clear_s, scan_en_s, decide_s;
  logic        accept_s, contig_s;
  logic [16:0] addr_ext_s, addr_plus1_s;
  logic [7:0]  w2_r, w1_r, w0_r;
  logic [7:0]  w2_nxt_s, w1_nxt_s, w0_nxt_s;
  logic [15:0] prev_addr_r;
  logic        have_prev_r;
  logic [16:0] rom_size_r;
  logic        e0_r, e7_r, fe_r, f3_r;
  logic        hit_e0_s, hit_e7_s, hit_fe_s, hit_3f_s;
  logic [7:0]  byte0_r;
  logic        have_b0_r, sc_ok_r;
  logic [3:0]  bs_code_r;
  logic        bs_valid_r, sc_det_r;

  assign dl_rise_s    = ioctl_download & ~dl_prev_r;
  assign dl_fall_s    = ~ioctl_download & dl_prev_r;
  assign addr_ext_s   = {1'b0, ioctl_addr[15:0]};
  assign addr_plus1_s = addr_ext_s + 17'd1;
  assign accept_s     = scan_en_s && ioctl_wr && (ioctl_addr[24:16] == 9'd0);
  assign contig_s     = have_prev_r && (addr_ext_s == ({1'b0, prev_addr_r} + 17'd1));

  // Download edge detector history.
  always_ff @(posedge clk) begin
    if (reset) dl_prev_r <= 1'b0;
    else       dl_prev_r <= ioctl_download;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   if (dl_rise_s) state_nxt_s = ST_SCAN;   else state_nxt_s = ST_IDLE;
      ST_SCAN:   if (dl_fall_s) state_nxt_s = ST_DECIDE; else state_nxt_s = ST_SCAN;
      ST_DECIDE: state_nxt_s = ST_DONE;
      ST_DONE:   if (dl_rise_s) state_nxt_s = ST_SCAN;   else state_nxt_s = ST_DONE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM control decodes.
  always_comb begin
    scan_clear_s = 1'b0;
    scan_en_s    = 1'b0;
    decide_s     = 1'b0;
    case (state_r)
      ST_IDLE:   scan_clear_s = dl_rise_s;
      ST_SCAN:   scan_en_s    = 1'b1;
      ST_DECIDE: decide_s     = 1'b1;
      ST_DONE:   scan_clear_s = dl_rise_s;
      default:   scan_clear_s = 1'b0;
    endcase
  end

  // Next window: a gap in addresses restarts the window from the new byte.
  // Zero fill is safe because no signature has 00 in its leading byte.
  always_comb begin
    w0_nxt_s = ioctl_dout;
    if (contig_s) begin
      w2_nxt_s = w1_r;
      w1_nxt_s = w0_r;
    end else begin
      w2_nxt_s = 8'h00;
      w1_nxt_s = 8'h00;
    end
  end

  bs_sig_match u_sig (
    .w2     (w2_nxt_s),
    .w1     (w1_nxt_s),
    .w0     (w0_nxt_s),
    .hit_e0 (hit_e0_s),
    .hit_e7 (hit_e7_s),
    .hit_fe (hit_fe_s),
    .hit_3f (hit_3f_s)
  );

  // Scan datapath: window, size tracking, sticky hits, SuperChip check.
  always_ff @(posedge clk) begin
    if (reset || scan_clear_s) begin
      w2_r        <= 8'h00;
      w1_r        <= 8'h00;
      w0_r        <= 8'h00;
      prev_addr_r <= 16'h0000;
      have_prev_r <= 1'b0;
      rom_size_r  <= 17'd0;
      e0_r        <= 1'b0;
      e7_r        <= 1'b0;
      fe_r        <= 1'b0;
      f3_r        <= 1'b0;
      byte0_r     <= 8'h00;
      have_b0_r   <= 1'b0;
      sc_ok_r     <= 1'b1;
    end else if (accept_s) begin
      w2_r        <= w2_nxt_s;
      w1_r        <= w1_nxt_s;
      w0_r        <= w0_nxt_s;
      prev_addr_r <= ioctl_addr[15:0];
      have_prev_r <= 1'b1;
      if (addr_plus1_s > rom_size_r) rom_size_r <= addr_plus1_s;
      e0_r <= e0_r | hit_e0_s;
      e7_r <= e7_r | hit_e7_s;
      fe_r <= fe_r | hit_fe_s;
      f3_r <= f3_r | hit_3f_s;
      if (addr_ext_s < SC_LEN_W) begin
        if (addr_ext_s == 17'd0) begin
          byte0_r   <= ioctl_dout;
          have_b0_r <= 1'b1;
          if (have_b0_r && (ioctl_dout != byte0_r)) sc_ok_r <= 1'b0;
        end else if (!have_b0_r || (ioctl_dout != byte0_r)) begin
          sc_ok_r <= 1'b0;
        end
      end
    end
  end

  // Decision outputs, registered on the DECIDE -> DONE transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      bs_code_r  <= BS_NONE;
      bs_valid_r <= 1'b0;
      sc_det_r   <= 1'b0;
    end else begin
      bs_valid_r <= decide_s;
      if (decide_s) begin
        bs_code_r <= bs_decide(rom_size_r, e0_r, e7_r, fe_r, f3_r);
        sc_det_r  <= sc_ok_r && have_b0_r && (rom_size_r >= SIZE_8K);
      end
    end
  end

  assign bs_code  = bs_code_r;
  assign bs_valid = bs_valid_r;
  assign sc_det   = sc_det_r;
  assign rom_size = rom_size_r;

endmodule

// File: doc/cart_bs_detect.md
# cart_bs_detect

Cartridge bank-switch auto-detector that sits directly upstream of the console core, on the ROM download path from `hps_io`. It snoops the `ioctl_*` byte stream while a ROM image loads into cartridge memory, scans it for bank-switch hotspot signatures and a SuperChip RAM fill pattern, and measures the image size. At the end of the download it publishes a bank-switch code in the core's `force_bs` encoding. The top level uses this code whenever the file extension does not force a scheme.

## Interface
Parameters:
- `SC_LEN`, default 128: number of leading image bytes that must be identical for a SuperChip hit.

Ports:
- `clk`, in, 1: system clock; the same clock as the `ioctl_*` bus.
- `reset`, in, 1: synchronous, active-high reset.
- `ioctl_download`, in, 1: high for the whole download.
- `ioctl_wr`, in, 1: one-cycle strobe per data byte.
- `ioctl_addr`, in, 25: byte address of the current data byte.
- `ioctl_dout`, in, 8: data byte.
- `bs_code`, out, 4: detected scheme; held until the next decision.
- `bs_valid`, out, 1: one-cycle pulse when `bs_code` and `sc_det` update.
- `sc_det`, out, 1: SuperChip detected; held.
- `rom_size`, out, 17: highest written address + 1; saturates at 17'h10000.

## Operation
- States: IDLE, SCAN, DECIDE, DONE.
- IDLE to SCAN on a rising edge of `ioctl_download`. DONE to SCAN on the same event. Entering SCAN clears all hit flags, the window and `rom_size`.
- In SCAN, a byte is accepted only when `ioctl_wr` is high and `ioctl_addr[24:16] == 0`. Other writes are ignored.
- Accepted byte handling:
  - Shift the byte into a 3-byte window (w2, w1, w0 = newest).
  - If `ioctl_addr` is not the previous accepted address + 1, reload the window with only the new byte, so non-contiguous bytes cannot form a match.
  - `rom_size <= max(rom_size, addr+1)`.
- Sticky hit flags, evaluated on the updated window:
  - E0: `8D E0 1F`, `8D E0 5F`, `8D E0 FF`, `AD E0 1F`.
  - E7: `AD E5 FF`, `8D E7 FF`.
  - FE: `20 00 D0`.
  - 3F: the 2-byte pair `85 3F` in w1/w0.
- SuperChip:
  - Byte 0 is latched.
  - `sc_ok` stays set only while every accepted byte with addr < `SC_LEN` equals byte 0.
  - `sc_det` requires `sc_ok` and `rom_size >= 8192`.
- SCAN to DECIDE on a falling edge of `ioctl_download`. DECIDE lasts exactly one cycle and computes the code. Priority is first match wins:
  - `rom_size` <= 4096: 0.
  - 3F hit: 5.
  - E0 hit and size 8192: 4.
  - FE hit and size 8192: 3.
  - Size 8192: 1 (F8).
  - Size 12288: 8 (FA).
  - Size 16384: E7 hit gives 12, otherwise 2 (F6).
  - Size 32768: 6 (F4).
  - Size 65536: 13 (F0).
  - Any other size: 0.
- DECIDE to DONE. `bs_valid` pulses on the DECIDE-to-DONE transition, with `bs_code` and `sc_det` registered at the same time.

## Timing
- Reset values: state IDLE; `bs_code = 0`, `bs_valid = 0`, `sc_det = 0`, `rom_size = 0`; all flags cleared.
- Reset during SCAN or DECIDE aborts the scan and returns to IDLE. No `bs_valid` pulse is produced.
- A window match is visible in the flags 1 cycle after the completing `ioctl_wr`.
- Latency: `bs_valid` is high in cycle N+2, where cycle N samples `ioctl_download` low after it was high. `bs_code` is stable from N+2.
- A falling edge of `ioctl_download` coinciding with a final `ioctl_wr`: that byte is accepted before the decision is taken.
- A download containing zero accepted bytes yields `bs_code = 0`, `sc_det = 0`, `rom_size = 0`. The `bs_valid` pulse still occurs.
- `rom_size` does not wrap: address 16'hFFFF yields 17'h10000.
- Back-to-back downloads: a new rising edge in DONE restarts SCAN. `bs_code` and `sc_det` keep their previous values until the new `bs_valid`.

## Structure
- Package `a2600_bs_pkg` holds:
  - localparams for the `force_bs` codes: NONE=0, F8=1, F6=2, FE=3, E0=4, 3F=5, F4=6, P2=7, FA=8, CV=9, UA=11, E7=12, F0=13, 32=14;
  - the state enum;
  - the size constants.
- Sub-module `bs_sig_match`: purely combinational. It takes the window and outputs the four hit strobes. The top block owns all state.

## Test plan
- 8K image of `00` with `8D E0 1F` at 0x0100: `bs_valid` pulse 2 cycles after download falls; `bs_code = 4`, `rom_size = 8192`.
- 16K image containing `AD E5 FF`: `bs_code = 12`. The same image without it: `bs_code = 2`.
- 8K image whose first 128 bytes are `FF`: `sc_det = 1`, `bs_code = 1`. Changing byte 0x7F to `00` gives `sc_det = 0`.
- `8D E0` written at 0x0200/0x0201 and `1F` at 0x0300: no E0 hit; 8K image gives `bs_code = 1`.
- 32K image containing `85 3F`: `bs_code = 5`.
- Assert `reset` mid-SCAN of a 16K image: no `bs_valid`; outputs return to 0. A following 4K download gives `bs_code = 0`, `rom_size = 4096`.
